// File: rtl/mic2941_shdwn_seq_pkg.sv
// Shared state encoding and default timing for the MIC2941 shutdown sequencer.
package mic2941_seq_pkg;

   localparam logic [2:0] ST_OFF     = 3'd0;
   localparam logic [2:0] ST_RAMP    = 3'd1;
   localparam logic [2:0] ST_ON      = 3'd2;
   localparam logic [2:0] ST_COOL    = 3'd3;
   localparam logic [2:0] ST_LOCKOUT = 3'd4;

   localparam int unsigned T_SETTLE_DEF   = 1000;
   localparam int unsigned T_DEBOUNCE_DEF = 16;
   localparam int unsigned T_COOL_DEF     = 4096;
   localparam int unsigned MAX_RETRY_DEF  = 3;
   localparam int unsigned CNT_W_DEF      = 16;
   localparam int unsigned RETRY_W_DEF    = 2;

endpackage

// File: rtl/mic2941_shdwn_seq_pgood_filter.sv
// Two-flop synchronizer on the raw PGOOD comparator followed by a
// consecutive-sample debounce; pg_f only moves after T_DEBOUNCE agreeing samples.
module pgood_filter #(
   parameter int unsigned T_DEBOUNCE = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic pgood,
   output logic pg_f
);

   localparam int unsigned DW = (T_DEBOUNCE > 1) ? $clog2(T_DEBOUNCE) : 1;
   localparam logic [DW-1:0] DB_LAST = DW'(T_DEBOUNCE - 1);
   localparam logic [DW-1:0] DB_ONE  = DW'(1);

   logic          s1, s2;
   logic [DW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1   <= 1'b0;
         s2   <= 1'b0;
         cnt  <= '0;
         pg_f <= 1'b0;
      end else begin
         s1 <= pgood;
         s2 <= s1;
         // any agreeing sample restarts the run of mismatches
         if (s2 == pg_f) begin
            cnt <= '0;
         end else if (cnt == DB_LAST) begin
            pg_f <= s2;
            cnt  <= '0;
         end else begin
            cnt <= cnt + DB_ONE;
         end
      end
   end

endmodule

// File: rtl/mic2941_shdwn_seq.sv
// Sequencer for the MIC2941 SHDWN pin: ramp, supervise, cool-down/retry and
// lockout. Outputs are registered and decoded from the next state.
module mic2941_shdwn_seq
   import mic2941_seq_pkg::*;
#(
   parameter int unsigned T_SETTLE   = T_SETTLE_DEF,
   parameter int unsigned T_DEBOUNCE = T_DEBOUNCE_DEF,
   parameter int unsigned T_COOL     = T_COOL_DEF,
   parameter int unsigned MAX_RETRY  = MAX_RETRY_DEF,
   parameter int unsigned CNT_W      = CNT_W_DEF,
   parameter int unsigned RETRY_W    = RETRY_W_DEF
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               ENABLE,
   input  logic               PGOOD,
   output logic               SHDWN,
   output logic               RAIL_OK,
   output logic               FAULT,
   output logic [RETRY_W-1:0] RETRY_CNT
);

   localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(T_SETTLE - 1);
   localparam logic [CNT_W-1:0]   COOL_LAST   = CNT_W'(T_COOL - 1);
   localparam logic [CNT_W-1:0]   TMR_ONE     = CNT_W'(1);
   localparam logic [RETRY_W-1:0] RETRY_ONE   = RETRY_W'(1);
   localparam logic [RETRY_W-1:0] RETRY_SAT   = '1;
   localparam logic [RETRY_W-1:0] RETRY_LIM   = RETRY_W'(MAX_RETRY);

   logic [2:0]         state, nxt;
   logic [CNT_W-1:0]   timer, timer_nxt;
   logic [RETRY_W-1:0] retry_nxt, retry_inc;
   logic               pg_f;

   pgood_filter #(.T_DEBOUNCE(T_DEBOUNCE)) u_filt (
      .clk   (CLK),
      .rst   (RESET),
      .pgood (PGOOD),
      .pg_f  (pg_f)
   );

   assign retry_inc = (RETRY_CNT == RETRY_SAT) ? RETRY_CNT : RETRY_CNT + RETRY_ONE;

   always_comb begin
      nxt       = state;
      timer_nxt = timer;
      retry_nxt = RETRY_CNT;
      if (!ENABLE) begin
         nxt       = ST_OFF;
         timer_nxt = '0;
         retry_nxt = '0;
      end else begin
         case (state)
            ST_OFF: begin
               nxt       = ST_RAMP;
               timer_nxt = '0;
            end
            ST_RAMP: begin
               // success is checked first so a last-cycle power-good still wins
               if (pg_f) begin
                  nxt       = ST_ON;
                  timer_nxt = '0;
               end else if (timer == SETTLE_LAST) begin
                  nxt       = ST_COOL;
                  timer_nxt = '0;
                  retry_nxt = retry_inc;
               end else begin
                  timer_nxt = timer + TMR_ONE;
               end
            end
            ST_ON: begin
               if (!pg_f) begin
                  nxt       = ST_COOL;
                  timer_nxt = '0;
                  retry_nxt = retry_inc;
               end else if (timer == COOL_LAST) begin
                  retry_nxt = '0;
               end else begin
                  timer_nxt = timer + TMR_ONE;
               end
            end
            ST_COOL: begin
               if (timer == COOL_LAST) begin
                  nxt       = (RETRY_CNT >= RETRY_LIM) ? ST_LOCKOUT : ST_RAMP;
                  timer_nxt = '0;
               end else begin
                  timer_nxt = timer + TMR_ONE;
               end
            end
            ST_LOCKOUT: nxt = ST_LOCKOUT;
            default:    nxt = ST_OFF;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state     <= ST_OFF;
         timer     <= '0;
         SHDWN     <= 1'b1;
         RAIL_OK   <= 1'b0;
         FAULT     <= 1'b0;
         RETRY_CNT <= '0;
      end else begin
         state     <= nxt;
         timer     <= timer_nxt;
         SHDWN     <= !((nxt == ST_RAMP) || (nxt == ST_ON));
         RAIL_OK   <= (nxt == ST_ON);
         FAULT     <= (nxt == ST_LOCKOUT);
         RETRY_CNT <= retry_nxt;
      end
   end

endmodule

// File: tb/tb_mic2941_shdwn_seq.sv
// Directed bench for mic2941_shdwn_seq with short sim timing constants.
module tb_mic2941_shdwn_seq;

   localparam int unsigned T_SETTLE   = 20;
   localparam int unsigned T_DEBOUNCE = 4;
   localparam int unsigned T_COOL     = 10;
   localparam int unsigned MAX_RETRY  = 2;

   logic       CLK = 1'b0;
   logic       RESET, ENABLE, PGOOD;
   logic       SHDWN, RAIL_OK, FAULT;
   logic [1:0] RETRY_CNT;

   int vecs = 0;
   int errs = 0;

   always #5 CLK = ~CLK;

   mic2941_shdwn_seq #(
      .T_SETTLE   (T_SETTLE),
      .T_DEBOUNCE (T_DEBOUNCE),
      .T_COOL     (T_COOL),
      .MAX_RETRY  (MAX_RETRY),
      .CNT_W      (16),
      .RETRY_W    (2)
   ) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .ENABLE    (ENABLE),
      .PGOOD     (PGOOD),
      .SHDWN     (SHDWN),
      .RAIL_OK   (RAIL_OK),
      .FAULT     (FAULT),
      .RETRY_CNT (RETRY_CNT)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   initial begin
      RESET = 1'b1; ENABLE = 1'b0; PGOOD = 1'b0;
      step(2);
      chk("rst_shdwn", SHDWN, 1);
      chk("rst_rail", RAIL_OK, 0);
      chk("rst_fault", FAULT, 0);
      chk("rst_retry", RETRY_CNT, 0);

      // power-up: PGOOD rises 5 cycles after SHDWN falls
      RESET = 1'b0; ENABLE = 1'b1;
      step(1);
      chk("ramp_shdwn", SHDWN, 0);
      step(5);
      PGOOD = 1'b1;
      step(6);
      chk("pg_lat_early", RAIL_OK, 0);
      step(1);
      chk("pg_lat", RAIL_OK, 1);
      chk("pg_fault", FAULT, 0);
      chk("pg_retry", RETRY_CNT, 0);

      // 3-cycle glitch is filtered
      PGOOD = 1'b0;
      step(3);
      PGOOD = 1'b1;
      step(8);
      chk("glitch_rail", RAIL_OK, 1);
      chk("glitch_shdwn", SHDWN, 0);

      // brown-out, cool-down, recovery, retry clear after 10 ON cycles
      PGOOD = 1'b0;
      step(6);
      chk("drop_early", RAIL_OK, 1);
      step(1);
      chk("drop_rail", RAIL_OK, 0);
      chk("drop_shdwn", SHDWN, 1);
      chk("drop_retry", RETRY_CNT, 1);
      PGOOD = 1'b1;
      step(9);
      chk("cool_end_shdwn", SHDWN, 1);
      step(1);
      chk("reramp_shdwn", SHDWN, 0);
      chk("reramp_rail", RAIL_OK, 0);
      step(1);
      chk("reon_rail", RAIL_OK, 1);
      chk("reon_retry", RETRY_CNT, 1);
      step(9);
      chk("retry_hold", RETRY_CNT, 1);
      step(1);
      chk("retry_clr", RETRY_CNT, 0);

      // reset pulse while ON with PGOOD high
      RESET = 1'b1;
      step(1);
      chk("midrst_shdwn", SHDWN, 1);
      chk("midrst_rail", RAIL_OK, 0);
      RESET = 1'b0;
      step(1);
      chk("postrst_shdwn", SHDWN, 0);
      chk("postrst_rail", RAIL_OK, 0);
      step(5);
      chk("postrst_rail_early", RAIL_OK, 0);
      step(1);
      chk("postrst_rail_up", RAIL_OK, 1);

      // disable from ON
      ENABLE = 1'b0;
      step(1);
      chk("dis_shdwn", SHDWN, 1);
      chk("dis_rail", RAIL_OK, 0);
      PGOOD = 1'b0;
      step(8);

      // PGOOD never comes: RAMP 20, COOL 10, RAMP 20, COOL 10, LOCKOUT
      ENABLE = 1'b1;
      for (int i = 1; i <= 61; i++) begin
         step(1);
         chk($sformatf("lock_shdwn_%0d", i), SHDWN,
             ((i >= 1 && i <= 20) || (i >= 31 && i <= 50)) ? 0 : 1);
         chk($sformatf("lock_fault_%0d", i), FAULT, (i >= 61) ? 1 : 0);
         chk($sformatf("lock_retry_%0d", i), RETRY_CNT, (i < 21) ? 0 : (i < 51) ? 1 : 2);
      end
      ENABLE = 1'b0;
      step(1);
      chk("unlock_fault", FAULT, 0);
      chk("unlock_retry", RETRY_CNT, 0);
      chk("unlock_shdwn", SHDWN, 1);

      // ENABLE dropped mid-RAMP, then mid-COOL; each re-enable gives a full RAMP
      ENABLE = 1'b1;
      step(1);
      chk("abort_ramp_start", SHDWN, 0);
      step(6);
      ENABLE = 1'b0;
      step(1);
      chk("abort_ramp_shdwn", SHDWN, 1);
      ENABLE = 1'b1;
      for (int i = 1; i <= 21; i++) begin
         step(1);
         chk($sformatf("ramp1_shdwn_%0d", i), SHDWN, (i == 21) ? 1 : 0);
      end
      chk("ramp1_retry", RETRY_CNT, 1);
      step(4);
      ENABLE = 1'b0;
      step(1);
      chk("abort_cool_shdwn", SHDWN, 1);
      chk("abort_cool_retry", RETRY_CNT, 0);
      ENABLE = 1'b1;
      for (int i = 1; i <= 21; i++) begin
         step(1);
         chk($sformatf("ramp2_shdwn_%0d", i), SHDWN, (i == 21) ? 1 : 0);
      end

      // pg_f asserts exactly in the last RAMP cycle: success beats timeout
      step(23);
      PGOOD = 1'b1;
      step(6);
      chk("edge_pre_rail", RAIL_OK, 0);
      chk("edge_pre_shdwn", SHDWN, 0);
      step(1);
      chk("edge_rail", RAIL_OK, 1);
      chk("edge_shdwn", SHDWN, 0);
      chk("edge_retry", RETRY_CNT, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
